multi_clock_div: RTL
====================

# multi_clock_div

Parametrised, runtime-programmable multi-channel clock divider generating CHANNELS independent 50 %-duty divided clocks from the 100 MHz system clock. Each channel also emits a one-cycle tick strobe per period. Per-channel divide ratios are loaded through a valid/ready config port and applied only at period boundaries, so no output ever has a runt pulse. Drives display multiplexing, debouncers and slow-blink logic in place of fixed single-ratio dividers.

## Interface
- CHANNELS, 4: number of independent divider channels (1–16).
- COUNT_WIDTH, 17: width of each half-period counter and half-period value.
- DEFAULT_HALF, 0: half-period value loaded into every channel at reset. 0 gives divide-by-2, which is the testbench setting.
- clock  input  1  100 MHz system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  CHANNELS  per-channel run enable.
- sync  input  1  one-cycle pulse; phase-aligns all channels.
- cfg_valid  input  1  config write request.
- cfg_chan  input  CHAN_W  target channel, where CHAN_W = max(1, clog2(CHANNELS)).
- cfg_half  input  COUNT_WIDTH  new half-period value H.
- cfg_ready  output  1  config write accepted when cfg_valid && cfg_ready.
- div_clock  output  CHANNELS  divided clocks, registered.
- tick  output  CHANNELS  one-cycle strobes, registered.

## Operation
- Divide ratio: 2·(H+1). The output toggles after every H+1 enabled cycles. Counter range is 0..H with no overflow; H = 2^COUNT_WIDTH−1 is legal.
- Per-channel state:
  - half register.
  - pending register plus pending flag.
  - counter.
  - div_clock bit.
- Enabled channel, each cycle:
  - If counter == H: counter ← 0 and div_clock toggles.
  - Otherwise: counter increments.
- tick ← 1 exactly on the edge where div_clock goes 0→1; otherwise tick ← 0.
- Disabled channel:
  - counter ← 0, div_clock ← 0, tick ← 0.
  - A pending value is applied on the next edge.
- Config handshake:
  - cfg_ready is combinational: 0 only when cfg_chan < CHANNELS and that channel already has pending set.
  - An accepted write sets pending ← cfg_half and the pending flag ← 1.
  - A write with cfg_chan ≥ CHANNELS is accepted with cfg_ready = 1 and discarded.
- Apply point: the edge where div_clock goes 1→0 (counter == H, div_clock == 1). On that edge:
  - half ← pending, pending flag ← 0, counter ← 0.
  - The next period uses the new H.
- Simultaneous events:
  - Write accepted on the same edge as that channel's apply point: the pending flag was clear, so the value lands in pending and applies at the following boundary.
  - sync: on that edge, all channels get counter ← 0, div_clock ← 0, tick ← 0, and any set pending is applied.
  - reset beats sync. sync beats the normal count. sync together with a cfg write: the write goes to pending and is not applied this edge.
- Reset values:
  - div_clock = 0, tick = 0, counters = 0.
  - half = DEFAULT_HALF, pending flags = 0.
  - cfg_ready = 1 whenever pending is clear.
- Reset asserted mid-period: outputs go low on the next edge and any pending update is lost.

## Timing
- Edge 1 is the first edge with reset = 0 and enable = 1.
  - div_clock rises after edge H+1 and falls after edge 2(H+1).
  - tick is high for the single cycle after edge H+1.
- Re-enabling a channel restarts at edge 1 of this numbering.
- cfg_ready has zero-cycle response to cfg_chan. Write acceptance happens on the same edge as the handshake.
- Latency from write to new period: at most one full old period, 2·(H_old+1) cycles, plus one cycle.

## Structure
- Package clock_div_pkg holds:
  - the CHAN_W computation function;
  - the COUNT_WIDTH default;
  - a localparam for the 100 MHz → 1 kHz half value (49999).
- Sub-module div_channel holds one channel: counter, half, pending, div_clock, tick.
  - Ports: clock, reset, enable, sync, wr_en, wr_half, pending_out, div_clock, tick.
- multi_clock_div instantiates CHANNELS copies with a genvar generate loop and decodes cfg_chan into the per-channel wr_en and cfg_ready.

## Test plan
- Reset, DEFAULT_HALF = 0, all enabled → every div_clock toggles every cycle (divide-by-2), and tick is high on alternate cycles starting in the cycle after edge 1.
- Write H = 3 to channel 1 while running at H = 0 → new period of 8 cycles begins exactly after the next 1→0 edge. Other channels stay unchanged.
- Two back-to-back writes to channel 2 → cfg_ready drops to 0 for channel 2 until the apply edge. A simultaneous write to channel 0 is accepted.
- Channels at H = 1 and H = 4, then a sync pulse mid-period → both outputs go 0 on that edge and both rise together in phase after 2 cycles and 5 cycles respectively.
- Drop enable on channel 3 mid-high-phase → div_clock goes 0 next edge and no tick is emitted. Re-enabling gives the first rise after H+1 edges.
- Assert reset while a write is pending on channel 0 → after reset, half = DEFAULT_HALF, the pending flag is clear and cfg_ready = 1. A write to cfg_chan = CHANNELS is accepted and has no effect.

Source files
------------

// File: rtl/multi_clock_div_pkg.sv
// Shared constants and width helpers for the multi-channel clock divider.
package clock_div_pkg;

   localparam int COUNT_WIDTH_DEF = 17;

   // Half-period for 100 MHz -> 1 kHz: 2 * (49999 + 1) = 100000 cycles
   localparam int HALF_1KHZ = 49999;

   function automatic int chan_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_clock_div_if.sv
// Config write port of the clock divider: valid/ready handshake carrying a channel index and half-period.
interface multi_clock_div_if
   import clock_div_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
);

   localparam int CHAN_W = chan_w(CHANNELS);

   logic                   cfg_valid;
   logic [CHAN_W-1:0]      cfg_chan;
   logic [COUNT_WIDTH-1:0] cfg_half;
   logic                   cfg_ready;

   modport master (output cfg_valid, output cfg_chan, output cfg_half, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_chan, input cfg_half, output cfg_ready);

endinterface

// File: rtl/multi_clock_div_channel.sv
// One divider channel: half-period counter, 50% output, rising-edge tick and a
// pending half-period that only takes effect at a period boundary.
module div_channel
   import clock_div_pkg::*;
#(
   parameter int          COUNT_WIDTH  = COUNT_WIDTH_DEF,
   parameter int unsigned DEFAULT_HALF = 0
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   sync,
   input  logic                   wr_en,
   input  logic [COUNT_WIDTH-1:0] wr_half,
   output logic                   pending_out,
   output logic                   div_clock,
   output logic                   tick
);

   logic [COUNT_WIDTH-1:0] half_q, half_d;
   logic [COUNT_WIDTH-1:0] pend_q, pend_d;
   logic                   pend_flag_q, pend_flag_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   div_q, div_d;
   logic                   tick_q, tick_d;
   logic                   apply;

   always_comb begin
      half_d      = half_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      tick_d      = 1'b0;
      apply       = 1'b0;

      if (sync || !enable) begin
         cnt_d = '0;
         div_d = 1'b0;
         apply = pend_flag_q;
      end else if (cnt_q == half_q) begin
         cnt_d  = '0;
         div_d  = ~div_q;
         tick_d = ~div_q;
         // The falling edge closes a full period, so a new ratio can start cleanly here
         apply  = div_q && pend_flag_q;
      end else begin
         cnt_d = cnt_q + COUNT_WIDTH'(1);
      end

      if (apply) begin
         half_d      = pend_q;
         pend_flag_d = 1'b0;
      end

      // Only accepted while the flag is clear, so it never collides with an apply
      if (wr_en) begin
         pend_d      = wr_half;
         pend_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         half_q      <= COUNT_WIDTH'(DEFAULT_HALF);
         pend_q      <= '0;
         pend_flag_q <= 1'b0;
         cnt_q       <= '0;
         div_q       <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         half_q      <= half_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         tick_q      <= tick_d;
      end
   end

   assign pending_out = pend_flag_q;
   assign div_clock   = div_q;
   assign tick        = tick_q;

endmodule

// File: rtl/multi_clock_div.sv
// Multi-channel programmable clock divider: CHANNELS independent divider channels
// sharing one config write port and a common phase-align pulse.
module multi_clock_div
   import clock_div_pkg::*;
#(
   parameter int          CHANNELS     = 4,
   parameter int          COUNT_WIDTH  = COUNT_WIDTH_DEF,
   parameter int unsigned DEFAULT_HALF = 0
)(
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] enable,
   input  logic                sync,
   multi_clock_div_if.slave    cfg,
   output logic [CHANNELS-1:0] div_clock,
   output logic [CHANNELS-1:0] tick
);

   localparam int CHAN_W = chan_w(CHANNELS);

   logic [CHANNELS-1:0] pend_flag;
   logic [CHANNELS-1:0] wr_en;
   logic                chan_busy;

   // Out-of-range indices match no channel: never busy, write silently dropped
   always_comb begin
      chan_busy = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg.cfg_chan == CHAN_W'(i) && pend_flag[i]) chan_busy = 1'b1;
      end
   end

   assign cfg.cfg_ready = ~chan_busy;

   always_comb begin
      wr_en = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_en[i] = cfg.cfg_valid && !chan_busy && (cfg.cfg_chan == CHAN_W'(i));
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      div_channel #(
         .COUNT_WIDTH  (COUNT_WIDTH),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_chan (
         .clock       (clock),
         .reset       (reset),
         .enable      (enable[g]),
         .sync        (sync),
         .wr_en       (wr_en[g]),
         .wr_half     (cfg.cfg_half),
         .pending_out (pend_flag[g]),
         .div_clock   (div_clock[g]),
         .tick        (tick[g])
      );
   end

endmodule
